// File: rtl/rca_operand_feeder_pkg.sv
// Shared definitions for the ripple-carry adder operand feeder: widths and FSM state encoding.
package rca_pkg;

  localparam int OPW    = 64;
  localparam int BEAT_W = 32;
  localparam int BEATS  = OPW / BEAT_W;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    ADD,
    HOLD
  } feeder_state_t;

endpackage : rca_pkg

// File: rtl/rca_beat_assembler.sv
// Beat counter plus slice-write register: assembles BEATS narrow beats, least-significant first,
// into one OPW-wide word. Slices are overwritten in place, so untouched slices keep old contents.
module rca_beat_assembler
  import rca_pkg::*;
#(
  parameter int OPW    = rca_pkg::OPW,
  parameter int BEAT_W = rca_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [OPW-1:0]    data_o,
  output logic              last_o
);

  localparam int NBEATS = OPW / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]   data_q, data_d;

  assign last_o = (cnt_q == CNT_W'(NBEATS - 1));
  assign data_o = data_q;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (load_en_i) begin
      data_d[cnt_q*BEAT_W +: BEAT_W] = beat_i;
      cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule : rca_beat_assembler

// File: rtl/rca_operand_feeder.sv
// Operand feeder for the external 64-bit ripple-carry adder: assembles a/b from beats, allows one
// settle cycle, captures sum/cout into a handshaked result buffer. Optional macro RCA_FEEDER_OVF_EN
// adds a registered signed-overflow flag res_ovf.
module rca_operand_feeder
  import rca_pkg::*;
#(
  parameter int OPW    = rca_pkg::OPW,
  parameter int BEAT_W = rca_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_cin,
  output logic [OPW-1:0]    a_o,
  output logic [OPW-1:0]    b_o,
  output logic              cin_o,
  input  logic [OPW-1:0]    sum_i,
  input  logic              cout_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OPW-1:0]    res_sum,
  output logic              res_cout
`ifdef RCA_FEEDER_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  generate
    if ((OPW % BEAT_W) != 0) begin : g_bad_beat_w
      $error("rca_operand_feeder: OPW must be a multiple of BEAT_W");
    end
  endgenerate

  feeder_state_t  state_q;
  logic           in_ready_q;
  logic           res_valid_q;
  logic [OPW-1:0] res_sum_q;
  logic           res_cout_q;
  logic           cin_q;
  logic           a_first_q;

  logic           accept;
  logic           load_a, load_b;
  logic           a_last, b_last;
  logic [OPW-1:0] a_q, b_q;

  // in_ready is masked by reset so no beat can be seen as accepted while rst_n is low.
  assign in_ready = rst_n & in_ready_q;
  assign accept   = in_valid & in_ready_q;
  assign load_a   = accept & (state_q == LOAD_A);
  assign load_b   = accept & (state_q == LOAD_B);

  rca_beat_assembler #(.OPW(OPW), .BEAT_W(BEAT_W)) u_asm_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en_i (load_a),
    .beat_i    (in_data),
    .data_o    (a_q),
    .last_o    (a_last)
  );

  rca_beat_assembler #(.OPW(OPW), .BEAT_W(BEAT_W)) u_asm_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en_i (load_b),
    .beat_i    (in_data),
    .data_o    (b_q),
    .last_o    (b_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      cin_q       <= 1'b0;
      a_first_q   <= 1'b1;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (load_a) begin
            if (a_first_q) cin_q <= in_cin;
            a_first_q <= a_last;
            if (a_last) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_b && b_last) begin
            state_q    <= ADD;
            in_ready_q <= 1'b0;
          end
        end
        ADD: begin
          res_sum_q   <= sum_i;
          res_cout_q  <= cout_i;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= LOAD_A;
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign cin_o     = cin_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;

`ifdef RCA_FEEDER_OVF_EN
  logic res_ovf_q;

  // Signed overflow: operands share a sign that the sum does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ovf_q <= 1'b0;
    end else if (state_q == ADD) begin
      res_ovf_q <= (a_q[OPW-1] == b_q[OPW-1]) && (sum_i[OPW-1] != a_q[OPW-1]);
    end
  end

  assign res_ovf = res_ovf_q;
`else
  // Overflow flag not built in this configuration.
`endif

endmodule : rca_operand_feeder

// File: tb/tb_rca_operand_feeder.sv
// Self-checking bench for rca_operand_feeder with a behavioural adder beside it and a result scoreboard.
module tb_rca_operand_feeder;

  localparam int OPW   = 64;
  localparam int BW    = 32;
  localparam int BEATS = OPW / BW;

  typedef struct {
    logic [OPW-1:0] sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [BW-1:0]  in_data = '0;
  logic           in_cin = 1'b0;
  logic [OPW-1:0] a_o, b_o, sum_i, res_sum;
  logic           cin_o, cout_i, res_valid, res_cout;
  logic           res_ready = 1'b1;
  logic [OPW:0]   add_full;
`ifdef RCA_FEEDER_OVF_EN
  logic           res_ovf;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Behavioural ripple-carry adder instantiated beside the feeder.
  assign add_full = {1'b0, a_o} + {1'b0, b_o} + {{OPW{1'b0}}, cin_o};
  assign sum_i    = add_full[OPW-1:0];
  assign cout_i   = add_full[OPW];

  rca_operand_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .a_o       (a_o),
    .b_o       (b_o),
    .cin_o     (cin_o),
    .sum_i     (sum_i),
    .cout_i    (cout_i),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout)
`ifdef RCA_FEEDER_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result consumer side: compare every handshaken result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", res_sum, '0);
        chk("unexpected_result_cnt", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_sum", res_sum, e.sum);
        chk("res_cout", {63'd0, res_cout}, {63'd0, e.cout});
`ifdef RCA_FEEDER_OVF_EN
        chk("res_ovf", {63'd0, res_ovf}, {63'd0, e.ovf});
`endif
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] d, input logic c, output int acc_cyc);
    int n;
    in_data  = d;
    in_cin   = c;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("beat_accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic c,
                         input bit gaps, output int first_cyc);
    exp_t e;
    logic [OPW:0] full;
    int acc;
    full   = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, c};
    e.sum  = full[OPW-1:0];
    e.cout = full[OPW];
    e.ovf  = (a[OPW-1] == b[OPW-1]) && (e.sum[OPW-1] != a[OPW-1]);
    sb.push_back(e);
    first_cyc = 0;
    for (int k = 0; k < 2 * BEATS; k++) begin
      if (gaps && ($urandom_range(1) == 1)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      if (k < BEATS) send_beat(a[k*BW +: BW], (k == 0) ? c : ~c, acc);
      else           send_beat(b[(k-BEATS)*BW +: BW], ~c, acc);
      if (k == 0) first_cyc = acc;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c1, c2, dummy;
    logic [OPW-1:0] ra, rb;

    // Reset state
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_a", a_o, '0);
    chk("rst_b", b_o, '0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_sum", res_sum, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Carry across the beat boundary, latency and throughput
    res_ready = 1'b1;
    send_op(64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, c1);
    chk("lat_add_no_valid", {63'd0, res_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {63'd0, res_valid}, 64'd1);
    chk("t1_sum_lit", res_sum, 64'h0000_0002_0000_0000);
    chk("t1_cout_lit", {63'd0, res_cout}, 64'd0);
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, c2);
    chk("throughput", 64'(c2 - c1), 64'd6);
    @(posedge clk);
    #1;
    chk("t2_sum_lit", res_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_cout_lit", {63'd0, res_cout}, 64'd1);
    chk("t2_cin_o", {63'd0, cin_o}, 64'd1);
    drain("drain_t2");

    // Signed overflow vectors (sum/cout checked in every build)
    send_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, dummy);
    @(posedge clk);
    #1;
    chk("ovf_sum_lit", res_sum, 64'h8000_0000_0000_0000);
`ifdef RCA_FEEDER_OVF_EN
    chk("ovf_set_lit", {63'd0, res_ovf}, 64'd1);
`endif
    send_op(64'h1, 64'h1, 1'b0, 1'b0, dummy);
    @(posedge clk);
    #1;
    chk("noovf_sum_lit", res_sum, 64'h2);
`ifdef RCA_FEEDER_OVF_EN
    chk("ovf_clr_lit", {63'd0, res_ovf}, 64'd0);
`endif
    drain("drain_ovf");

    // Backpressure in HOLD with a pending beat
    res_ready = 1'b0;
    ra = 64'h1234_5678_9ABC_DEF0;
    rb = 64'h0FED_CBA9_8765_4321;
    send_op(ra, rb, 1'b1, 1'b0, dummy);
    in_data  = 32'hCAFE_F00D;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
      chk("hold_res_sum", res_sum, ra + rb + 64'd1);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    send_op(64'h0000_0001_CAFE_F00D, 64'h0000_0002_0000_0003, 1'b0, 1'b0, dummy);
    drain("drain_hold");

    // Reset after 3 of 4 beats
    send_beat(32'hDEAD_BEEF, 1'b1, dummy);
    send_beat(32'hA5A5_A5A5, 1'b0, dummy);
    send_beat(32'h5555_AAAA, 1'b0, dummy);
    rst_n = 1'b0;
    #2;
    chk("mrst_a", a_o, '0);
    chk("mrst_b", b_o, '0);
    chk("mrst_cin", {63'd0, cin_o}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mrst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mrst_res_sum", res_sum, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_op(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 1'b0, dummy);
    @(posedge clk);
    #1;
    chk("mrst_fresh_sum", res_sum, 64'h30);
    drain("drain_rst");

    // Random operands with random input gaps
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 97 == 0) rb = ~ra;
      send_op(ra, rb, 1'($urandom_range(1)), 1'b1, dummy);
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rca_operand_feeder
